// File: rtl/sine_capture.sv
// Measures period and peak levels of an offset-binary waveform between rising midscale crossings.
// Define SINE_CAPTURE_HYST_EN to lower the arm threshold to 512-HYST.
module sine_capture #(
  parameter int MAX_PERIOD = 4095,
  parameter int HYST       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [9:0]  sample,
  output logic [11:0] period,
  output logic [9:0]  peak_max,
  output logic [9:0]  peak_min,
  output logic        result_valid,
  output logic        locked,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

`ifdef SINE_CAPTURE_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam logic [9:0]  MID    = 10'd512;
  localparam logic [9:0]  ARM_TH = HYST_ON ? 10'(512 - HYST) : 10'd512;
  localparam logic [11:0] MAXP   = 12'(MAX_PERIOD);

  state_t      r_state;
  state_t      w_next;
  logic        r_armed;
  logic [11:0] r_count;
  logic [9:0]  r_run_max;
  logic [9:0]  r_run_min;
  logic        w_arm;
  logic        w_cross;
  logic        w_cnt_full;
  logic        w_start;
  logic        w_latch;
  logic        w_tmo;
  logic [11:0] w_count_inc;

  assign w_arm       = (sample < ARM_TH);
  assign w_cross     = r_armed && (sample >= MID);
  assign w_count_inc = r_count + 12'd1;
  // A crossing always wins over the limit, so only non-crossing samples may time out.
  assign w_cnt_full  = (w_count_inc == MAXP);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, advanced only by accepted samples
  always_comb begin
    w_next = r_state;
    if (sample_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_arm) w_next = S_ARMED;
          else       w_next = S_IDLE;
        end
        S_ARMED: begin
          if (w_cross)         w_next = S_MEASURE;
          else if (w_cnt_full) w_next = S_IDLE;
          else                 w_next = S_ARMED;
        end
        S_MEASURE: begin
          if (!w_cross && w_cnt_full) w_next = S_IDLE;
          else                        w_next = S_MEASURE;
        end
        default: w_next = S_IDLE;
      endcase
    end else begin
      w_next = r_state;
    end
  end

  // Control strobes decoded from state and the accepted sample
  always_comb begin
    w_start = 1'b0;
    w_latch = 1'b0;
    w_tmo   = 1'b0;
    if (sample_valid) begin
      case (r_state)
        S_ARMED: begin
          w_start = w_cross;
          w_tmo   = !w_cross && w_cnt_full;
        end
        S_MEASURE: begin
          w_start = w_cross;
          w_latch = w_cross;
          w_tmo   = !w_cross && w_cnt_full;
        end
        default: begin
          w_start = 1'b0;
          w_latch = 1'b0;
          w_tmo   = 1'b0;
        end
      endcase
    end else begin
      w_start = 1'b0;
      w_latch = 1'b0;
      w_tmo   = 1'b0;
    end
  end

  // Datapath: arm flag, sample counter, running extremes and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed      <= 1'b0;
      r_count      <= 12'd0;
      r_run_max    <= 10'd0;
      r_run_min    <= 10'd1023;
      period       <= 12'd0;
      peak_max     <= 10'd0;
      peak_min     <= 10'd1023;
      result_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= w_latch;
      timeout      <= w_tmo;

      if (w_tmo)                      r_armed <= 1'b0;
      else if (sample_valid && w_cross) r_armed <= 1'b0;
      else if (sample_valid && w_arm)   r_armed <= 1'b1;
      else                            r_armed <= r_armed;

      if (w_start)                                 r_count <= 12'd1;
      else if (w_tmo)                              r_count <= 12'd0;
      else if (sample_valid && r_state != S_IDLE)  r_count <= w_count_inc;
      else                                         r_count <= r_count;

      if (w_start) begin
        r_run_max <= sample;
        r_run_min <= sample;
      end else if (sample_valid && r_state == S_MEASURE) begin
        r_run_max <= (sample > r_run_max) ? sample : r_run_max;
        r_run_min <= (sample < r_run_min) ? sample : r_run_min;
      end else begin
        r_run_max <= r_run_max;
        r_run_min <= r_run_min;
      end

      // The crossing sample opens the next cycle, so latch before reloading.
      if (w_latch) begin
        period   <= r_count;
        peak_max <= r_run_max;
        peak_min <= r_run_min;
      end else begin
        period   <= period;
        peak_max <= peak_max;
        peak_min <= peak_min;
      end

      if (w_latch)    locked <= 1'b1;
      else if (w_tmo) locked <= 1'b0;
      else            locked <= locked;
    end
  end

endmodule
